// File: rtl/ct_ifu_lbuf_create_ctrl.sv
// rtl/ct_ifu_lbuf_create_ctrl.sv - loop buffer fill controller (IDLE/FILL/CACHE)
// Optional capture counter under LBUF_CREATE_CAPTURE_CNT_EN.
module ct_ifu_lbuf_create_ctrl #(
  parameter int ENTRY_NUM = 16,
  parameter int PTR_W     = 5
) (
  input  logic                      forever_cpuclk,
  input  logic                      cpurst_b,
  input  logic                      lbuf_flush,
  input  logic                      ibctrl_lbuf_loop_hit,
  input  logic [1:0]                ibdp_lbuf_hw_vld,
  input  logic [31:0]               ibdp_lbuf_hw_data,
  input  logic [1:0]                ibdp_lbuf_hw_32_start,
  input  logic [1:0]                ibdp_lbuf_hw_front_br,
  input  logic [1:0]                ibdp_lbuf_hw_back_br,
  output logic                      lbuf_ibdp_ready,
  output logic                      fill_state_enter,
  output logic [ENTRY_NUM-1:0]      entry_create_x,
  output logic [ENTRY_NUM-1:0]      entry_create_clk_en_x,
  output logic [16*ENTRY_NUM-1:0]   entry_create_inst_data_v,
  output logic [ENTRY_NUM-1:0]      entry_create_32_start_x,
  output logic [ENTRY_NUM-1:0]      entry_create_front_br_x,
  output logic [ENTRY_NUM-1:0]      entry_create_back_br_x,
  output logic                      lbuf_active,
  output logic                      lbuf_fill_abort,
  output logic [15:0]               lbuf_capture_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_CACHE = 2'd2
  } state_t;

  state_t                    r_state, w_state_nxt;
  logic [PTR_W-1:0]          r_wptr, w_wptr_nxt;
  logic [1:0]                w_n;
  logic [PTR_W:0]            w_wptr_sum;
  logic                      w_fits;
  logic                      w_accept;
  logic                      w_back_hit;
  logic                      w_fill_enter_nxt;
  logic                      w_abort_nxt;

  logic [15:0]               w_a_data;
  logic                      w_a_start, w_a_front, w_a_back;

  logic [ENTRY_NUM-1:0]      w_create_nxt, w_start_nxt, w_front_nxt, w_back_nxt;
  logic [16*ENTRY_NUM-1:0]   w_data_nxt;

  logic [ENTRY_NUM-1:0]      r_create, r_start, r_front, r_back;
  logic [16*ENTRY_NUM-1:0]   r_data;
  logic                      r_fill_enter;
  logic                      r_abort;

  // A back branch in the older halfword ends the loop body, so hw1 is dropped.
  always_comb begin
    w_n = 2'd0;
    case (ibdp_lbuf_hw_vld)
      2'b00:   w_n = 2'd0;
      2'b01:   w_n = 2'd1;
      2'b10:   w_n = 2'd1;
      default: w_n = ibdp_lbuf_hw_back_br[0] ? 2'd1 : 2'd2;
    endcase
  end

  assign w_a_data   = ibdp_lbuf_hw_vld[0] ? ibdp_lbuf_hw_data[15:0] : ibdp_lbuf_hw_data[31:16];
  assign w_a_start  = ibdp_lbuf_hw_vld[0] ? ibdp_lbuf_hw_32_start[0] : ibdp_lbuf_hw_32_start[1];
  assign w_a_front  = ibdp_lbuf_hw_vld[0] ? ibdp_lbuf_hw_front_br[0] : ibdp_lbuf_hw_front_br[1];
  assign w_a_back   = ibdp_lbuf_hw_vld[0] ? ibdp_lbuf_hw_back_br[0]  : ibdp_lbuf_hw_back_br[1];

  assign w_wptr_sum = {1'b0, r_wptr} + {{(PTR_W-1){1'b0}}, w_n};
  assign w_fits     = (w_wptr_sum <= (PTR_W+1)'(ENTRY_NUM));
  assign w_accept   = (r_state == ST_FILL) && !lbuf_flush && (w_n != 2'd0) && w_fits;
  assign w_back_hit = w_accept && (w_a_back || ((w_n == 2'd2) && ibdp_lbuf_hw_back_br[1]));

  always_comb begin
    w_state_nxt      = r_state;
    w_wptr_nxt       = r_wptr;
    w_fill_enter_nxt = 1'b0;
    w_abort_nxt      = 1'b0;
    if (lbuf_flush) begin
      w_state_nxt = ST_IDLE;
      w_wptr_nxt  = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (ibctrl_lbuf_loop_hit) begin
            w_state_nxt      = ST_FILL;
            w_fill_enter_nxt = 1'b1;
            w_wptr_nxt       = '0;
          end
        end
        ST_FILL: begin
          if (w_n != 2'd0) begin
            if (w_fits) begin
              w_wptr_nxt = w_wptr_sum[PTR_W-1:0];
              if (w_back_hit) w_state_nxt = ST_CACHE;
            end else begin
              w_state_nxt = ST_IDLE;
              w_abort_nxt = 1'b1;
              w_wptr_nxt  = '0;
            end
          end
        end
        ST_CACHE: w_state_nxt = ST_CACHE;
        default: begin
          w_state_nxt = ST_IDLE;
          w_wptr_nxt  = '0;
        end
      endcase
    end
  end

  // Oldest accepted halfword lands at wptr, the second (if any) at wptr+1.
  always_comb begin
    w_create_nxt = '0;
    w_start_nxt  = '0;
    w_front_nxt  = '0;
    w_back_nxt   = '0;
    w_data_nxt   = '0;
    for (int i = 0; i < ENTRY_NUM; i++) begin
      if (w_accept && (PTR_W'(i) == r_wptr)) begin
        w_create_nxt[i]        = 1'b1;
        w_data_nxt[16*i +: 16] = w_a_data;
        w_start_nxt[i]         = w_a_start;
        w_front_nxt[i]         = w_a_front;
        w_back_nxt[i]          = w_a_back;
      end
      if (w_accept && (w_n == 2'd2) && (PTR_W'(i) == (r_wptr + PTR_W'(1)))) begin
        w_create_nxt[i]        = 1'b1;
        w_data_nxt[16*i +: 16] = ibdp_lbuf_hw_data[31:16];
        w_start_nxt[i]         = ibdp_lbuf_hw_32_start[1];
        w_front_nxt[i]         = ibdp_lbuf_hw_front_br[1];
        w_back_nxt[i]          = ibdp_lbuf_hw_back_br[1];
      end
    end
  end

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      r_state      <= ST_IDLE;
      r_wptr       <= '0;
      r_fill_enter <= 1'b0;
      r_abort      <= 1'b0;
      r_create     <= '0;
      r_start      <= '0;
      r_front      <= '0;
      r_back       <= '0;
      r_data       <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_wptr       <= w_wptr_nxt;
      r_fill_enter <= w_fill_enter_nxt;
      r_abort      <= w_abort_nxt;
      r_create     <= w_create_nxt;
      r_start      <= w_start_nxt;
      r_front      <= w_front_nxt;
      r_back       <= w_back_nxt;
      r_data       <= w_data_nxt;
    end
  end

`ifdef LBUF_CREATE_CAPTURE_CNT_EN
  logic [15:0] r_capture_cnt;

  // Survives flush; only reset clears it.
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      r_capture_cnt <= 16'h0;
    end else if ((r_state == ST_FILL) && (w_state_nxt == ST_CACHE) && (r_capture_cnt != 16'hFFFF)) begin
      r_capture_cnt <= r_capture_cnt + 16'd1;
    end
  end

  assign lbuf_capture_cnt = r_capture_cnt;
`else
  assign lbuf_capture_cnt = 16'h0;
`endif

  assign lbuf_ibdp_ready          = (r_state == ST_FILL);
  assign lbuf_active              = (r_state == ST_CACHE);
  assign fill_state_enter         = r_fill_enter;
  assign lbuf_fill_abort          = r_abort;
  assign entry_create_x           = r_create;
  assign entry_create_clk_en_x    = r_create;
  assign entry_create_inst_data_v = r_data;
  assign entry_create_32_start_x  = r_start;
  assign entry_create_front_br_x  = r_front;
  assign entry_create_back_br_x   = r_back;

endmodule

// File: tb/tb_ct_ifu_lbuf_create_ctrl.sv
// tb/tb_ct_ifu_lbuf_create_ctrl.sv - scoreboard bench for the loop buffer fill controller
module tb_ct_ifu_lbuf_create_ctrl;

  localparam int EN = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            flush = 1'b0;
  logic            hit = 1'b0;
  logic [1:0]      vld = '0;
  logic [31:0]     data = '0;
  logic [1:0]      s32 = '0, fbr = '0, bbr = '0;
  logic            ready, fse, active, abort_o;
  logic [EN-1:0]   cre, cre_en, cst, cfb, cbb;
  logic [16*EN-1:0] cdata;
  logic [15:0]     cnt;

  always #5 clk = ~clk;

  ct_ifu_lbuf_create_ctrl #(.ENTRY_NUM(EN), .PTR_W(5)) dut (
    .forever_cpuclk          (clk),
    .cpurst_b                (rst_n),
    .lbuf_flush              (flush),
    .ibctrl_lbuf_loop_hit    (hit),
    .ibdp_lbuf_hw_vld        (vld),
    .ibdp_lbuf_hw_data       (data),
    .ibdp_lbuf_hw_32_start   (s32),
    .ibdp_lbuf_hw_front_br   (fbr),
    .ibdp_lbuf_hw_back_br    (bbr),
    .lbuf_ibdp_ready         (ready),
    .fill_state_enter        (fse),
    .entry_create_x          (cre),
    .entry_create_clk_en_x   (cre_en),
    .entry_create_inst_data_v(cdata),
    .entry_create_32_start_x (cst),
    .entry_create_front_br_x (cfb),
    .entry_create_back_br_x  (cbb),
    .lbuf_active             (active),
    .lbuf_fill_abort         (abort_o),
    .lbuf_capture_cnt        (cnt)
  );

  typedef struct {
    logic [EN-1:0]    mask;
    logic [16*EN-1:0] data;
    logic [EN-1:0]    st, fb, bb;
    logic             fse, abort, active, ready;
    logic [15:0]      cnt;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  bit   mon_en = 1'b0;
  int   cyc = 0;

  // Reference model: mode 0=idle 1=filling 2=captured
  int   m_mode = 0;
  int   m_wptr = 0;
  logic [15:0] m_cnt = 16'h0;

  task automatic chk(input string name, input logic [16*EN-1:0] act, input logic [16*EN-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic exp_t idle_rec();
    exp_t e;
    e = '{default: '0};
    e.cnt = m_cnt;
    return e;
  endfunction

  task automatic step(input bit h, input bit fl, input logic [1:0] v, input logic [31:0] d,
                      input logic [1:0] s, input logic [1:0] f, input logic [1:0] b);
    exp_t e;
    int   hw[$];
    int   nm, np, idx;
    hit = h; flush = fl; vld = v; data = d; s32 = s; fbr = f; bbr = b;
    e = '{default: '0};
    nm = m_mode;
    np = m_wptr;
    if (fl) begin
      nm = 0; np = 0;
    end else if (m_mode == 0) begin
      if (h) begin nm = 1; np = 0; e.fse = 1'b1; end
    end else if (m_mode == 1) begin
      for (int k = 0; k < 2; k++) if (v[k]) hw.push_back(k);
      if (v[0] && b[0]) begin hw.delete(); hw.push_back(0); end
      if (hw.size() > 0) begin
        if (m_wptr + hw.size() > EN) begin
          nm = 0; np = 0; e.abort = 1'b1;
        end else begin
          foreach (hw[j]) begin
            idx = m_wptr + j;
            e.mask[idx] = 1'b1;
            e.data[16*idx +: 16] = d[16*hw[j] +: 16];
            e.st[idx] = s[hw[j]];
            e.fb[idx] = f[hw[j]];
            e.bb[idx] = b[hw[j]];
            if (b[hw[j]]) nm = 2;
          end
          np = m_wptr + hw.size();
        end
      end
    end
`ifdef LBUF_CREATE_CAPTURE_CNT_EN
    if (m_mode == 1 && nm == 2 && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
`endif
    m_mode = nm;
    m_wptr = np;
    e.active = (nm == 2);
    e.ready  = (nm == 1);
    e.cnt    = m_cnt;
    q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic hs(input bit h, input bit fl, input logic [1:0] v, input logic [1:0] b);
    step(h, fl, v, $urandom, 2'($urandom), 2'($urandom), b);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    logic [16*EN-1:0] md;
    cyc++;
    if (mon_en) begin
      if (q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL scoreboard_empty cycle %0d", cyc);
      end else begin
        e = q.pop_front();
        md = '0;
        for (int i = 0; i < EN; i++) if (e.mask[i]) md[16*i +: 16] = cdata[16*i +: 16];
        chk("create",   {{(15*EN){1'b0}}, cre}, {{(15*EN){1'b0}}, e.mask});
        chk("clk_en",   {{(15*EN){1'b0}}, cre_en}, {{(15*EN){1'b0}}, e.mask});
        chk("data",     md, e.data);
        chk("flags",    {{(13*EN){1'b0}}, cst & e.mask, cfb & e.mask, cbb & e.mask},
                        {{(13*EN){1'b0}}, e.st, e.fb, e.bb});
        chk("ctrl",     {{(16*EN-4){1'b0}}, fse, abort_o, active, ready},
                        {{(16*EN-4){1'b0}}, e.fse, e.abort, e.active, e.ready});
        chk("capture_cnt", {{(16*EN-16){1'b0}}, cnt}, {{(16*EN-16){1'b0}}, e.cnt});
      end
    end
  end

  task automatic check_all_zero(input string tag);
    chk({tag, "_create"}, {{(15*EN){1'b0}}, cre | cre_en | cst | cfb | cbb}, '0);
    chk({tag, "_data"}, cdata, '0);
    chk({tag, "_ctrl"}, {{(16*EN-4){1'b0}}, fse, abort_o, active, ready}, '0);
    chk({tag, "_cnt"}, {{(16*EN-16){1'b0}}, cnt}, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset_state");
    #1;
    rst_n = 1'b1;
    q.push_back(idle_rec());
    mon_en = 1'b1;

    // basic capture: six halfwords, back branch in the last one
    hs(1, 0, 2'b00, 2'b00);
    hs(0, 0, 2'b11, 2'b00);
    hs(0, 0, 2'b11, 2'b00);
    hs(0, 0, 2'b11, 2'b10);
    hs(1, 0, 2'b11, 2'b00);
    hs(0, 1, 2'b00, 2'b00);

    // back branch in hw0 while hw1 is valid
    hs(1, 0, 2'b00, 2'b00);
    hs(0, 0, 2'b11, 2'b01);
    hs(0, 0, 2'b11, 2'b00);
    hs(0, 1, 2'b00, 2'b00);

    // overflow at wptr=15
    hs(1, 0, 2'b00, 2'b00);
    for (int i = 0; i < 7; i++) hs(0, 0, 2'b11, 2'b00);
    hs(0, 0, 2'b01, 2'b00);
    hs(0, 0, 2'b11, 2'b00);
    hs(0, 0, 2'b11, 2'b00);

    // last entry taken with a back branch
    hs(1, 0, 2'b00, 2'b00);
    for (int i = 0; i < 7; i++) hs(0, 0, 2'b11, 2'b00);
    hs(0, 0, 2'b01, 2'b00);
    hs(0, 0, 2'b01, 2'b01);
    hs(0, 1, 2'b00, 2'b00);

    // full buffer is legal, the next halfword aborts
    hs(1, 0, 2'b00, 2'b00);
    for (int i = 0; i < 8; i++) hs(0, 0, 2'b11, 2'b00);
    hs(0, 0, 2'b10, 2'b00);
    hs(0, 0, 2'b00, 2'b00);

    // flush mid-fill, then flush together with loop_hit
    hs(1, 0, 2'b00, 2'b00);
    hs(0, 0, 2'b11, 2'b00);
    hs(0, 1, 2'b11, 2'b00);
    hs(0, 0, 2'b11, 2'b00);
    hs(1, 1, 2'b00, 2'b00);
    hs(0, 0, 2'b11, 2'b00);
    hs(0, 0, 2'b00, 2'b00);

`ifdef LBUF_CREATE_CAPTURE_CNT_EN
    force dut.r_capture_cnt = 16'hFFFE;
    #1;
    release dut.r_capture_cnt;
    m_cnt = 16'hFFFE;
    q[q.size()-1].cnt = 16'hFFFE;
    hs(1, 0, 2'b00, 2'b00);
    hs(0, 0, 2'b01, 2'b01);
    hs(0, 1, 2'b00, 2'b00);
    hs(1, 0, 2'b00, 2'b00);
    hs(0, 0, 2'b11, 2'b10);
    hs(0, 1, 2'b00, 2'b00);
`endif

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      hs(($urandom % 6) == 0, ($urandom % 40) == 0, 2'($urandom),
         {($urandom % 10) == 0, ($urandom % 10) == 0});
    end

    // asynchronous reset while a create is on the outputs
    hs(0, 1, 2'b00, 2'b00);
    hs(1, 0, 2'b00, 2'b00);
    hs(0, 0, 2'b11, 2'b10);
    mon_en = 1'b0;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    @(posedge clk);
    #1;
    check_all_zero("reset_hold");
    #1;
    rst_n = 1'b1;
    m_mode = 0;
    m_wptr = 0;
    m_cnt = 16'h0;
    q.delete();
    q.push_back(idle_rec());
    mon_en = 1'b1;
    hs(1, 0, 2'b00, 2'b00);
    hs(0, 0, 2'b11, 2'b00);
    hs(0, 0, 2'b01, 2'b01);
    hs(0, 0, 2'b00, 2'b00);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
